bresenham_stream: RTL and testbench
===================================

Name: bresenham_stream

Overview:
Parametrised successor to the fixed-length line rasteriser.
- Accepts one line command (x0,y0)->(x1,y1) in any octant.
- Walks the integer Bresenham path and streams one pixel per accepted transfer over a valid/ready handshake.
- Has no maximum line length; the line length is bounded only by the coordinate widths.
- Sits between the vertex/projection stage and the framebuffer write arbiter.

Parameters:
P_X_COORD_W, 11, x coordinate width (unsigned)
P_Y_COORD_W, 11, y coordinate width (unsigned)
P_X_MAX, 1023, largest visible x (used only with clipping)
P_Y_MAX, 767, largest visible y (used only with clipping)
P_CNT_W, max(P_X_COORD_W,P_Y_COORD_W)+1, point-index counter width (derived; do not override)

Ports:
i_clk  in  1  clock
i_reset  in  1  reset, asynchronous, active-high
i_x0  in  P_X_COORD_W  start x
i_y0  in  P_Y_COORD_W  start y
i_x1  in  P_X_COORD_W  end x
i_y1  in  P_Y_COORD_W  end y
i_load_vals  in  1  command valid; accepted only when o_waiting=1
o_waiting  out  1  idle, ready for a command
o_x_val  out  P_X_COORD_W  current pixel x
o_y_val  out  P_Y_COORD_W  current pixel y
o_val_valid  out  1  pixel valid
i_val_ready  in  1  downstream accepts pixel
o_val_last  out  1  current pixel is the final pixel of the line
o_vals_counter  out  P_CNT_W  index of the current pixel within the line (0-based)
o_line_done  out  1  one-cycle pulse when the line walk completes

Behaviour:
- Reset (asynchronous, active-high):
  - State returns to IDLE immediately.
  - o_waiting=1.
  - o_x_val, o_y_val, o_vals_counter = 0.
  - o_val_valid, o_val_last, o_line_done = 0.
  - Asserting reset mid-line aborts the line; no further pixels are emitted.
- State machine: IDLE -> SETUP -> EMIT -> IDLE.
- IDLE:
  - o_waiting=1.
  - If i_load_vals=1, latch x0,y0,x1,y1 and go to SETUP.
  - Input changes after acceptance are ignored.
- SETUP (exactly 1 cycle):
  - dx=|x1-x0|, dy=-|y1-y0|, sx=sign(x1-x0), sy=sign(y1-y0), err=dx+dy.
  - Signed arithmetic is max(W)+2 bits wide, so no overflow at full-scale coordinates.
  - Load the current point with (x0,y0) and set the counter to 0.
- EMIT:
  - o_val_valid=1.
  - o_val_last=1 when the current point equals (x1,y1).
- Latency: the first pixel is valid 2 cycles after the accepting edge of i_load_vals.
- Handshake:
  - A transfer occurs on a cycle where o_val_valid && i_val_ready.
  - While o_val_valid=1 and i_val_ready=0, o_x_val, o_y_val, o_val_last and o_vals_counter hold stable.
  - Maximum throughput is 1 pixel/cycle with i_val_ready held high.
- Step on a non-last transfer: with e2=2*err:
  - if e2>=dy: err+=dy, x+=sx;
  - if e2<=dx: err+=dx, y+=sy.
  - Both updates may apply in the same cycle.
  - Increment the counter.
- Transfer of the last pixel:
  - Go to IDLE and pulse o_line_done for 1 cycle; o_val_valid drops the same cycle.
  - o_waiting rises the cycle after the last transfer.
- Point count is max(dx,|dy|)+1. A degenerate line (x0==x1 and y0==y1) emits one pixel with o_val_last=1.
- i_load_vals in SETUP or EMIT is ignored; no queueing.
- The line is emitted strictly from (x0,y0) toward (x1,y1), with endpoints inclusive.

Optional Feature:
Macro BRESENHAM_CLIP_EN.
- Defined:
  - A point with x>P_X_MAX or y>P_Y_MAX is walked internally but not presented: o_val_valid=0 for it, and it advances one step per cycle without a handshake.
  - o_vals_counter counts presented pixels only.
  - o_val_last asserts only if the endpoint is visible.
  - o_line_done still pulses when the walk ends.
- Undefined: every point is presented, P_X_MAX and P_Y_MAX are unused, and no clip comparators are synthesised.

Decomposition:
- Shared package bresenham_pkg:
  - state enum (IDLE, SETUP, EMIT);
  - log2/clog2 width functions;
  - derived error-term width constant.
- One natural sub-module, bresenham_step: combinational next (x, y, err) from current (x, y, err, dx, dy, sx, sy).
- The top level holds the FSM, the registers and the handshake.

Test Plan:
1. Reset, then load (5,5)->(0,0) with ready=1:
   - pixels (5,5),(4,4),(3,3),(2,2),(1,1),(0,0) on consecutive cycles;
   - counter 0..5; last on (0,0); o_line_done pulses once.
2. Load (5,5)->(10,3):
   - exactly (5,5),(6,5),(7,4),(8,4),(9,3),(10,3);
   - first valid 2 cycles after load.
3. Backpressure: load (5,5)->(10,5) and hold i_val_ready=0 for 3 cycles after the first valid:
   - (5,5) and counter 0 stay stable;
   - the remaining pixels follow (6,5)..(10,5) without loss or duplication.
4. Degenerate and busy cases:
   - load (5,5)->(5,5): a single pixel with last=1, then o_waiting=1;
   - pulse i_load_vals with new coordinates during EMIT: ignored, original line completes.
5. Reset asserted mid-line (after 3 pixels of (0,0)->(10,10)):
   - all outputs 0 immediately and o_waiting=1;
   - a new load (0,0)->(0,10) then emits 11 pixels along y.
6. With BRESENHAM_CLIP_EN and P_X_MAX=7, load (5,5)->(10,5):
   - presents (5,5),(6,5),(7,5) with counter 0..2 and no last;
   - o_line_done pulses after the walk reaches (10,5).

Source files
------------

// File: rtl/bresenham_pkg.sv
// bresenham_pkg: shared definitions for the streaming line rasteriser.
//   state_t        - walk sequencer states (IDLE, SETUP, EMIT)
//   max_w          - larger of two widths
//   log2_f/clog2_f - floor/ceiling log2 width helpers
//   err_width      - width of the signed error/delta terms; ERR_GUARD_BITS
//                    of headroom above the widest coordinate keeps dx+dy and
//                    2*err free of overflow at full-scale coordinates.
package bresenham_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam int ERR_GUARD_BITS = 2;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int log2_f(input int v);
        int r;
        r = 0;
        while ((v >> (r + 1)) > 0) r++;
        return r;
    endfunction

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int err_width(input int xw, input int yw);
        return max_w(xw, yw) + ERR_GUARD_BITS;
    endfunction

endpackage

// File: rtl/bresenham_step.sv
// bresenham_step: one combinational Bresenham step.
//   x, y        - current point
//   err         - current error term (signed)
//   dx, dy      - |x1-x0| and -|y1-y0| (signed)
//   sx_neg      - x walks downward; sy_neg - y walks downward
//   x_next, y_next, err_next - point and error after one step
// Both axis updates are decided from the same e2 = 2*err, so a diagonal
// step applies both in one call.
module bresenham_step #(
    parameter int P_X_COORD_W = 11,
    parameter int P_Y_COORD_W = 11,
    parameter int P_ERR_W     = 13
) (
    input  logic        [P_X_COORD_W-1:0] x,
    input  logic        [P_Y_COORD_W-1:0] y,
    input  logic signed [P_ERR_W-1:0]     err,
    input  logic signed [P_ERR_W-1:0]     dx,
    input  logic signed [P_ERR_W-1:0]     dy,
    input  logic                          sx_neg,
    input  logic                          sy_neg,
    output logic        [P_X_COORD_W-1:0] x_next,
    output logic        [P_Y_COORD_W-1:0] y_next,
    output logic signed [P_ERR_W-1:0]     err_next
);

    // One extra bit so doubling the error can never wrap.
    logic signed [P_ERR_W:0] e2;
    logic signed [P_ERR_W:0] dx_ext;
    logic signed [P_ERR_W:0] dy_ext;
    logic                    step_x;
    logic                    step_y;

    always_comb begin
        e2       = {err, 1'b0};
        dx_ext   = {dx[P_ERR_W-1], dx};
        dy_ext   = {dy[P_ERR_W-1], dy};
        step_x   = (e2 >= dy_ext);
        step_y   = (e2 <= dx_ext);
        err_next = err;
        x_next   = x;
        y_next   = y;
        if (step_x) begin
            err_next = err_next + dy;
            x_next   = sx_neg ? (x - P_X_COORD_W'(1)) : (x + P_X_COORD_W'(1));
        end
        if (step_y) begin
            err_next = err_next + dx;
            y_next   = sy_neg ? (y - P_Y_COORD_W'(1)) : (y + P_Y_COORD_W'(1));
        end
    end

endmodule

// File: rtl/bresenham_stream.sv
// bresenham_stream: accepts one line command and streams its Bresenham
// pixels, endpoints inclusive, over a valid/ready handshake.
//   i_clk, i_reset          - clock, asynchronous active-high reset
//   i_x0..i_y1, i_load_vals - line command, taken only while o_waiting=1
//   o_waiting               - idle, ready for a command
//   o_x_val, o_y_val        - current pixel
//   o_val_valid/i_val_ready - pixel handshake
//   o_val_last              - current pixel is the line endpoint
//   o_vals_counter          - 0-based index of the current pixel
//   o_line_done             - one-cycle pulse after the walk completes
// Optional macro BRESENHAM_CLIP_EN: points beyond P_X_MAX/P_Y_MAX are walked
// one per cycle without being presented; the counter and the last flag then
// refer to presented pixels only.
module bresenham_stream
    import bresenham_pkg::*;
#(
    parameter int P_X_COORD_W = 11,
    parameter int P_Y_COORD_W = 11,
    parameter int P_X_MAX     = 1023,
    parameter int P_Y_MAX     = 767,
    parameter int P_CNT_W     = max_w(P_X_COORD_W, P_Y_COORD_W) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [P_X_COORD_W-1:0] i_x0,
    input  logic [P_Y_COORD_W-1:0] i_y0,
    input  logic [P_X_COORD_W-1:0] i_x1,
    input  logic [P_Y_COORD_W-1:0] i_y1,
    input  logic                   i_load_vals,
    output logic                   o_waiting,
    output logic [P_X_COORD_W-1:0] o_x_val,
    output logic [P_Y_COORD_W-1:0] o_y_val,
    output logic                   o_val_valid,
    input  logic                   i_val_ready,
    output logic                   o_val_last,
    output logic [P_CNT_W-1:0]     o_vals_counter,
    output logic                   o_line_done
);

    localparam int EW = err_width(P_X_COORD_W, P_Y_COORD_W);

    state_t                   state_reg;
    logic [P_X_COORD_W-1:0]   x0_reg, x1_reg, x_reg;
    logic [P_Y_COORD_W-1:0]   y0_reg, y1_reg, y_reg;
    logic signed [EW-1:0]     err_reg;
    logic [P_CNT_W-1:0]       cnt_reg;
    logic                     valid_reg, last_reg, done_reg, waiting_reg;

    // Line deltas come straight from the latched command, which is frozen
    // for the whole walk, so they need no registers of their own.
    logic signed [EW-1:0]     x_diff, y_diff, dx_w, dy_w;
    logic                     sx_neg, sy_neg;

    assign x_diff = $signed(EW'(x1_reg)) - $signed(EW'(x0_reg));
    assign y_diff = $signed(EW'(y1_reg)) - $signed(EW'(y0_reg));
    assign sx_neg = x_diff[EW-1];
    assign sy_neg = y_diff[EW-1];
    assign dx_w   = sx_neg ? -x_diff : x_diff;
    assign dy_w   = sy_neg ? y_diff : -y_diff;

    logic [P_X_COORD_W-1:0]   x_step;
    logic [P_Y_COORD_W-1:0]   y_step;
    logic signed [EW-1:0]     err_step;

    bresenham_step #(
        .P_X_COORD_W (P_X_COORD_W),
        .P_Y_COORD_W (P_Y_COORD_W),
        .P_ERR_W     (EW)
    ) u_step (
        .x        (x_reg),
        .y        (y_reg),
        .err      (err_reg),
        .dx       (dx_w),
        .dy       (dy_w),
        .sx_neg   (sx_neg),
        .sy_neg   (sy_neg),
        .x_next   (x_step),
        .y_next   (y_step),
        .err_next (err_step)
    );

    logic vis_first, vis_next;

`ifdef BRESENHAM_CLIP_EN
    assign vis_first = (int'(x0_reg) <= P_X_MAX) && (int'(y0_reg) <= P_Y_MAX);
    assign vis_next  = (int'(x_step) <= P_X_MAX) && (int'(y_step) <= P_Y_MAX);
`else
    // Without clipping every point is visible; the limits fold to a constant.
    localparam bit LIMITS_SET = (P_X_MAX >= 0) && (P_Y_MAX >= 0);
    assign vis_first = LIMITS_SET;
    assign vis_next  = LIMITS_SET;
`endif

    logic at_end, start_is_end, next_is_end, advance;

    assign at_end       = (x_reg == x1_reg) && (y_reg == y1_reg);
    assign start_is_end = (x0_reg == x1_reg) && (y0_reg == y1_reg);
    assign next_is_end  = (x_step == x1_reg) && (y_step == y1_reg);
    // A hidden point never waits for the consumer.
    assign advance      = !valid_reg || i_val_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg   <= IDLE;
            x0_reg      <= '0;
            y0_reg      <= '0;
            x1_reg      <= '0;
            y1_reg      <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            err_reg     <= '0;
            cnt_reg     <= '0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
            done_reg    <= 1'b0;
            waiting_reg <= 1'b1;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_load_vals) begin
                        x0_reg      <= i_x0;
                        y0_reg      <= i_y0;
                        x1_reg      <= i_x1;
                        y1_reg      <= i_y1;
                        waiting_reg <= 1'b0;
                        state_reg   <= SETUP;
                    end
                end
                SETUP: begin
                    x_reg     <= x0_reg;
                    y_reg     <= y0_reg;
                    err_reg   <= dx_w + dy_w;
                    cnt_reg   <= '0;
                    valid_reg <= vis_first;
                    last_reg  <= vis_first && start_is_end;
                    state_reg <= EMIT;
                end
                EMIT: begin
                    if (advance) begin
                        if (at_end) begin
                            valid_reg   <= 1'b0;
                            last_reg    <= 1'b0;
                            done_reg    <= 1'b1;
                            waiting_reg <= 1'b1;
                            state_reg   <= IDLE;
                        end else begin
                            x_reg     <= x_step;
                            y_reg     <= y_step;
                            err_reg   <= err_step;
                            valid_reg <= vis_next;
                            last_reg  <= vis_next && next_is_end;
                            // Only presented pixels consume an index.
                            if (valid_reg) begin
                                cnt_reg <= cnt_reg + P_CNT_W'(1);
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_waiting      = waiting_reg;
    assign o_x_val        = x_reg;
    assign o_y_val        = y_reg;
    assign o_val_valid    = valid_reg;
    assign o_val_last     = last_reg;
    assign o_vals_counter = cnt_reg;
    assign o_line_done    = done_reg;

endmodule

// File: tb/tb_bresenham_stream.sv
module tb_bresenham_stream;

    localparam int XW       = 11;
    localparam int YW       = 11;
    localparam int CW       = 12;
    localparam int TB_X_MAX = 7;
    localparam int TB_Y_MAX = 767;
`ifdef BRESENHAM_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_reset;
    logic [XW-1:0] i_x0, i_x1;
    logic [YW-1:0] i_y0, i_y1;
    logic          i_load_vals;
    logic          o_waiting;
    logic [XW-1:0] o_x_val;
    logic [YW-1:0] o_y_val;
    logic          o_val_valid;
    logic          i_val_ready;
    logic          o_val_last;
    logic [CW-1:0] o_vals_counter;
    logic          o_line_done;

    always #5 clk = ~clk;

    bresenham_stream #(
        .P_X_COORD_W (XW),
        .P_Y_COORD_W (YW),
        .P_X_MAX     (TB_X_MAX),
        .P_Y_MAX     (TB_Y_MAX)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_x0           (i_x0),
        .i_y0           (i_y0),
        .i_x1           (i_x1),
        .i_y1           (i_y1),
        .i_load_vals    (i_load_vals),
        .o_waiting      (o_waiting),
        .o_x_val        (o_x_val),
        .o_y_val        (o_y_val),
        .o_val_valid    (o_val_valid),
        .i_val_ready    (i_val_ready),
        .o_val_last     (o_val_last),
        .o_vals_counter (o_vals_counter),
        .o_line_done    (o_line_done)
    );

    typedef struct {
        int x;
        int y;
        int idx;
        bit last;
    } pix_t;

    pix_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   xfers      = 0;
    int   done_cnt   = 0;
    bit   done_due   = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Reference walk: the textbook integer Bresenham loop on plain ints,
    // keeping only the visible points when clipping is on.
    function automatic void gen_line(input int x0, input int y0, input int x1, input int y1,
                                     input bit clip, output pix_t q[$]);
        int dx, dy, sx, sy, err, e2, x, y, n;
        bit vis, fin;
        q.delete();
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x   = x0;
        y   = y0;
        n   = 0;
        for (int guard = 0; guard < 5000; guard++) begin
            vis = !clip || ((x <= TB_X_MAX) && (y <= TB_Y_MAX));
            fin = (x == x1) && (y == y1);
            if (vis) begin
                q.push_back('{x: x, y: y, idx: n, last: fin});
                n++;
            end
            if (fin) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    // Pins the reference walk against hand-computed pixel lists.
    task automatic pin(input string name, input int x0, input int y0, input int x1, input int y1,
                       input bit clip, input int lit[$], input bit end_visible);
        pix_t q[$];
        int   n;
        gen_line(x0, y0, x1, y1, clip, q);
        n = lit.size() / 2;
        chk({name, "_len"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            chk({name, "_x"}, q[i].x, lit[2*i]);
            chk({name, "_y"}, q[i].y, lit[2*i+1]);
            chk({name, "_idx"}, q[i].idx, i);
            chk({name, "_last"}, int'(q[i].last), int'(end_visible && (i == n - 1)));
        end
    endtask

    // Scoreboard: every mid-cycle, any presented pixel must match the head
    // of the expected queue; a pixel leaves the queue when it is accepted.
    always @(negedge clk) begin
        bit xfer_last;
        xfer_last = 1'b0;
        if (!i_reset) begin
            if (o_val_valid) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL extra_pixel: got (%0d,%0d) idx %0d, want no pixel",
                             o_x_val, o_y_val, o_vals_counter);
                end else begin
                    if (int'(o_x_val) != exp_q[0].x || int'(o_y_val) != exp_q[0].y ||
                        int'(o_vals_counter) != exp_q[0].idx || o_val_last != exp_q[0].last) begin
                        mismatched++;
                        $display("FAIL pixel: got (%0d,%0d) idx %0d last %0d, want (%0d,%0d) idx %0d last %0d",
                                 o_x_val, o_y_val, o_vals_counter, o_val_last,
                                 exp_q[0].x, exp_q[0].y, exp_q[0].idx, exp_q[0].last);
                    end
                    if (i_val_ready) begin
                        xfer_last = exp_q[0].last;
                        void'(exp_q.pop_front());
                        xfers++;
                    end
                end
            end
            if (o_line_done) begin
                chk("done_queue_empty", exp_q.size(), 0);
                chk("waiting_with_done", int'(o_waiting), 1);
                done_cnt++;
            end
`ifndef BRESENHAM_CLIP_EN
            chk("done_timing", int'(o_line_done), int'(done_due));
`endif
            done_due = xfer_last;
        end
    end

    task automatic load_line(input int x0, input int y0, input int x1, input int y1);
        pix_t q[$];
        bit   ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (o_waiting) ok = 1'b1;
        end
        chk("load_waiting", int'(ok), 1);
        @(posedge clk); #2;
        i_x0 = XW'(x0); i_y0 = YW'(y0); i_x1 = XW'(x1); i_y1 = YW'(y1);
        i_load_vals = 1'b1;
        gen_line(x0, y0, x1, y1, CLIP_ON, q);
        foreach (q[i]) exp_q.push_back(q[i]);
        @(posedge clk); #2;
        i_load_vals = 1'b0;
        // Scribble over the inputs: the accepted command must be unaffected.
        i_x0 = XW'(999); i_y0 = YW'(700); i_x1 = XW'(3); i_y1 = YW'(600);
    endtask

    task automatic wait_done(input string name, input int start);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk); #1;
            if (done_cnt > start) seen = 1'b1;
        end
        chk({name, "_done_seen"}, int'(seen), 1);
        repeat (3) @(negedge clk);
        #1;
        chk({name, "_done_once"}, done_cnt - start, 1);
        chk({name, "_all_pixels"}, exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_x"}, int'(o_x_val), 0);
        chk({name, "_y"}, int'(o_y_val), 0);
        chk({name, "_cnt"}, int'(o_vals_counter), 0);
        chk({name, "_valid"}, int'(o_val_valid), 0);
        chk({name, "_last"}, int'(o_val_last), 0);
        chk({name, "_done"}, int'(o_line_done), 0);
        chk({name, "_waiting"}, int'(o_waiting), 1);
    endtask

    initial begin
        int lit[$];
        int d0;
        int xb;
        bit hit;

        i_reset     = 1'b1;
        i_load_vals = 1'b0;
        i_val_ready = 1'b1;
        i_x0 = '0; i_y0 = '0; i_x1 = '0; i_y1 = '0;

        // Reference walk pinned to hand-worked lists
        lit = '{5,5, 4,4, 3,3, 2,2, 1,1, 0,0};
        pin("pin_diag", 5, 5, 0, 0, 1'b0, lit, 1'b1);
        lit = '{5,5, 6,5, 7,4, 8,4, 9,3, 10,3};
        pin("pin_shallow", 5, 5, 10, 3, 1'b0, lit, 1'b1);
        lit = '{5,5};
        pin("pin_point", 5, 5, 5, 5, 1'b0, lit, 1'b1);
        lit = '{5,5, 6,5, 7,5};
        pin("pin_clip", 5, 5, 10, 5, 1'b1, lit, 1'b0);

        // Reset state
        @(posedge clk); #2;
        check_idle_outputs("reset");
        i_reset = 1'b0;
        $display("reset released, outputs idle");

        // 1: diagonal toward the origin
        d0 = done_cnt;
        load_line(5, 5, 0, 0);
        wait_done("diag", d0);
        $display("line (5,5)->(0,0) done");

        // 2: shallow line plus first-pixel latency
        d0 = done_cnt;
        load_line(5, 5, 10, 3);
        @(negedge clk);
        chk("lat_setup_valid", int'(o_val_valid), 0);
        @(negedge clk);
        chk("lat_first_valid", int'(o_val_valid), 1);
        wait_done("shallow", d0);
        $display("line (5,5)->(10,3) done");

        // 3: backpressure on the first pixel
        d0 = done_cnt;
        xb = xfers;
        i_val_ready = 1'b0;
        load_line(5, 5, 10, 5);
        @(negedge clk);
        chk("bp_setup_valid", int'(o_val_valid), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(o_val_valid), 1);
            chk("bp_hold_x", int'(o_x_val), 5);
            chk("bp_hold_y", int'(o_y_val), 5);
            chk("bp_hold_cnt", int'(o_vals_counter), 0);
        end
        @(posedge clk); #2;
        i_val_ready = 1'b1;
        wait_done("bp", d0);
        chk("bp_pixel_count", xfers - xb, CLIP_ON ? 3 : 6);
        $display("line (5,5)->(10,5) with backpressure done");

        // 4a: degenerate single-point line
        d0 = done_cnt;
        load_line(5, 5, 5, 5);
        @(negedge clk);
        @(negedge clk);
        chk("point_valid", int'(o_val_valid), 1);
        chk("point_last", int'(o_val_last), 1);
        @(negedge clk);
        chk("point_waiting", int'(o_waiting), 1);
        chk("point_valid_drop", int'(o_val_valid), 0);
        chk("point_done", int'(o_line_done), 1);
        wait_done("point", d0);
        $display("line (5,5)->(5,5) done");

        // 4b: a command arriving mid-walk is ignored
        d0 = done_cnt;
        load_line(2, 1, 8, 4);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #2;
        i_x0 = XW'(100); i_y0 = YW'(100); i_x1 = XW'(200); i_y1 = YW'(150);
        i_load_vals = 1'b1;
        @(posedge clk); #2;
        i_load_vals = 1'b0;
        wait_done("busy", d0);
        repeat (4) @(negedge clk);
        #1;
        chk("busy_idle_valid", int'(o_val_valid), 0);
        chk("busy_idle_waiting", int'(o_waiting), 1);
        $display("line (2,1)->(8,4) with ignored load done");

        // 5: reset mid-line, then a vertical line
        xb = xfers;
        load_line(0, 0, 10, 10);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk); #1;
            if (xfers - xb >= 3) hit = 1'b1;
        end
        chk("abort_three_px_seen", int'(hit), 1);
        @(posedge clk); #2;
        i_reset = 1'b1;
        exp_q.delete();
        done_due = 1'b0;
        #1;
        check_idle_outputs("abort");
        chk("abort_px_before_reset", xfers - xb, 3);
        @(posedge clk); #2;
        i_reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_no_more_valid", int'(o_val_valid), 0);
        d0 = done_cnt;
        xb = xfers;
        load_line(0, 0, 0, 10);
        wait_done("vert", d0);
        chk("vert_pixel_count", xfers - xb, 11);
        $display("reset abort then line (0,0)->(0,10) done");

`ifdef BRESENHAM_CLIP_EN
        // 6: clipped walk presents only x<=7
        d0 = done_cnt;
        xb = xfers;
        load_line(5, 5, 10, 5);
        wait_done("clip", d0);
        chk("clip_pixel_count", xfers - xb, 3);
        $display("clipped line (5,5)->(10,5) done");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard stop guard in case the stimulus itself stalls.
    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "timeout");
    end

endmodule
